// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe elastic register pipeline.
// Optional occupancy counter is enabled by defining REG_PIPE_COUNT_EN.
package reg_pipe_pkg;

    localparam int REG_PIPE_WIDTH_DEF = 16;
    localparam int REG_PIPE_DEPTH_DEF = 4;

    function automatic int reg_pipe_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// Producer and consumer valid/ready handshake bundle for reg_pipe.
// master = environment side, slave = pipeline side.
interface reg_pipe_if
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = REG_PIPE_WIDTH_DEF
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/reg_pipe_stage.sv
// One elastic stage: valid+data register that loads when empty or draining.
// Latency 1 cycle; holds while full and downstream cannot take the item.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = REG_PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_dn_free,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_adv,
    output logic             o_free
);
    logic             r_vld;
    logic [WIDTH-1:0] r_dat;

    assign o_adv  = r_vld & i_dn_free;
    assign o_free = ~r_vld | o_adv;
    assign o_vld  = r_vld;
    assign o_dat  = r_dat;

    // Data only moves with a valid item, so an empty stage keeps its last value.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_vld <= 1'b0;
            r_dat <= RESET_VAL;
        end else if (o_free) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_dat <= i_dat;
            end
        end
    end
endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage elastic register pipeline, DEPTH cycles latency, bubbles collapse under backpressure.
// REG_PIPE_COUNT_EN adds a registered occupancy count port.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = REG_PIPE_WIDTH_DEF,
    parameter int               DEPTH     = REG_PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic       clock,
    input  logic       r,
    input  logic       flush,
    reg_pipe_if.slave  bus
`ifdef REG_PIPE_COUNT_EN
    ,
    output logic [reg_pipe_cnt_w(DEPTH)-1:0] count
`endif
);
    logic             w_vld  [DEPTH];
    logic [WIDTH-1:0] w_dat  [DEPTH];
    logic             w_adv  [DEPTH];
    logic             w_free [DEPTH];
    logic             w_in_rdy;
    logic             w_accept;
    logic             w_emit;

    assign w_in_rdy = w_free[0] & ~flush & ~r;
    assign w_accept = bus.in_valid & w_in_rdy;
    assign w_emit   = w_adv[DEPTH-1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             w_up_vld;
        logic [WIDTH-1:0] w_up_dat;
        logic             w_dn_free;

        if (g == 0) begin : g_head
            assign w_up_vld = w_accept;
            assign w_up_dat = bus.in_data;
        end else begin : g_body
            assign w_up_vld = w_vld[g-1];
            assign w_up_dat = w_dat[g-1];
        end

        if (g == DEPTH - 1) begin : g_tail
            assign w_dn_free = bus.out_ready;
        end else begin : g_link
            assign w_dn_free = w_free[g+1];
        end

        reg_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .i_clk     (clock),
            .i_rst     (r),
            .i_flush   (flush),
            .i_vld     (w_up_vld),
            .i_dat     (w_up_dat),
            .i_dn_free (w_dn_free),
            .o_vld     (w_vld[g]),
            .o_dat     (w_dat[g]),
            .o_adv     (w_adv[g]),
            .o_free    (w_free[g])
        );
    end

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = w_vld[DEPTH-1];
    assign bus.out_data  = w_dat[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
    localparam int CW = reg_pipe_cnt_w(DEPTH);
    logic [CW-1:0] r_count;

    // Internal stage-to-stage moves conserve occupancy; only the ends change it.
    always_ff @(posedge clock) begin
        if (r || flush) begin
            r_count <= '0;
        end else if (w_accept && !w_emit) begin
            r_count <= r_count + CW'(1);
        end else if (!w_accept && w_emit) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign count = r_count;
`endif
endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: directed scenarios plus random traffic against an item-level queue model.
module tb_reg_pipe;
    import reg_pipe_pkg::*;

    localparam int             W  = 16;
    localparam int             D  = 4;
    localparam logic [W-1:0]   RV = 16'h0000;

    logic clock = 1'b0;
    logic r;
    logic flush;

    reg_pipe_if #(.WIDTH(W)) bus ();

`ifdef REG_PIPE_COUNT_EN
    logic [reg_pipe_cnt_w(D)-1:0] count;
`endif

    reg_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clock (clock),
        .r     (r),
        .flush (flush),
        .bus   (bus)
`ifdef REG_PIPE_COUNT_EN
        ,
        .count (count)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Model: in-flight items oldest first, each with its stage position.
    logic [W-1:0] m_dat [$];
    int           m_pos [$];
    int           m_np  [$];
    logic [W-1:0] m_last = RV;
    logic         e_in_rdy, e_out_vld, e_emit;
    logic [W-1:0] e_out_dat;
    logic [W+1:0] e_vec;
    logic [W-1:0] obs [$];

    task automatic model_eval();
        int lim;
        int np;
        e_out_vld = (m_pos.size() > 0) && (m_pos[0] == D - 1);
        e_out_dat = e_out_vld ? m_dat[0] : m_last;
        e_emit    = e_out_vld && bus.out_ready;
        m_np      = {};
        lim       = D;
        foreach (m_pos[j]) begin
            if (j == 0 && e_emit) continue;
            np = (m_pos[j] + 1 < lim - 1) ? m_pos[j] + 1 : lim - 1;
            m_np.push_back(np);
            lim = np;
        end
        e_in_rdy = (lim >= 1) && !flush && !r;
        e_vec    = {e_in_rdy, e_out_vld, e_out_dat};
    endtask

    task automatic model_step();
        if (r || flush) begin
            m_dat  = {};
            m_pos  = {};
            m_last = RV;
        end else begin
            if (e_emit) void'(m_dat.pop_front());
            m_pos = m_np;
            if (bus.in_valid && e_in_rdy) begin
                m_dat.push_back(bus.in_data);
                m_pos.push_back(0);
            end
            if (m_pos.size() > 0 && m_pos[0] == D - 1) m_last = m_dat[0];
        end
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic tick();
        if (bus.out_valid && bus.out_ready) obs.push_back(bus.out_data);
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        r = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'hFFFF; bus.out_ready = 1'b1;
        repeat (2) begin
            settle();
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
                n_err++; $display("FAIL rst_in_ready_low: got %b want 0", bus.in_ready);
            end
            tick();
        end
        r = 1'b0; bus.in_valid = 1'b0;
        obs = {};
        settle();
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.out_data} !== {1'b1, 1'b0, RV}) begin
            n_err++;
            $display("FAIL rst_outputs: got %h want %h", {bus.in_ready, bus.out_valid, bus.out_data}, {1'b1, 1'b0, RV});
        end
        repeat (6) begin
            settle();
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_err++; $display("FAIL rst_no_item: got out_valid %b want 0", bus.out_valid);
            end
            tick();
        end
    endtask

    task automatic test_stream();
        int k = 0;
        int t_acc = -1;
        int t_out = -1;
        bus.out_ready = 1'b1; obs = {};
        for (int cyc = 0; cyc < 16; cyc++) begin
            bus.in_valid = (k < 8);
            bus.in_data  = 16'(k + 1);
            settle();
            n_cmp++;
            if ({bus.in_ready, bus.out_valid, bus.out_data} !== e_vec) begin
                n_err++;
                $display("FAIL stream_cyc%0d: got %h want %h", cyc, {bus.in_ready, bus.out_valid, bus.out_data}, e_vec);
            end
            if (bus.in_valid) begin
                n_cmp++;
                if (bus.in_ready !== 1'b1) begin
                    n_err++; $display("FAIL stream_in_ready cyc%0d: got %b want 1", cyc, bus.in_ready);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (t_acc < 0) t_acc = cyc;
                k++;
            end
            if (bus.out_valid && t_out < 0) t_out = cyc;
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (t_out - t_acc !== D) begin
            n_err++; $display("FAIL stream_latency: got %0d want %0d", t_out - t_acc, D);
        end
        n_cmp++;
        if (obs.size() !== 8) begin
            n_err++; $display("FAIL stream_count: got %0d want 8", obs.size());
        end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== 16'(i + 1)) begin
                n_err++; $display("FAIL stream_order[%0d]: got %h want %h", i, obs[i], 16'(i + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        bus.out_ready = 1'b0; obs = {};
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.in_valid = (k < 6);
            bus.in_data  = 16'(k + 1);
            settle();
            n_cmp++;
            if ({bus.in_ready, bus.out_valid, bus.out_data} !== e_vec) begin
                n_err++;
                $display("FAIL bp_cyc%0d: got %h want %h", cyc, {bus.in_ready, bus.out_valid, bus.out_data}, e_vec);
            end
            if (k >= 4) begin
                n_cmp++;
                if (bus.in_ready !== 1'b0) begin
                    n_err++; $display("FAIL bp_full cyc%0d: got in_ready %b want 0", cyc, bus.in_ready);
                end
            end
            if (bus.out_valid) begin
                n_cmp++;
                if (bus.out_data !== 16'h0001) begin
                    n_err++; $display("FAIL bp_stable cyc%0d: got %h want 0001", cyc, bus.out_data);
                end
            end
            if (bus.in_valid && bus.in_ready) k++;
            tick();
        end
        bus.out_ready = 1'b1;
        settle();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release: got in_ready %b want 1", bus.in_ready);
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.in_valid = (k < 6);
            bus.in_data  = 16'(k + 1);
            settle();
            n_cmp++;
            if ({bus.in_ready, bus.out_valid, bus.out_data} !== e_vec) begin
                n_err++;
                $display("FAIL bp_drain_cyc%0d: got %h want %h", cyc, {bus.in_ready, bus.out_valid, bus.out_data}, e_vec);
            end
            if (bus.in_valid && bus.in_ready) k++;
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (obs.size() !== 6) begin
            n_err++; $display("FAIL bp_count: got %0d want 6", obs.size());
        end
        for (int i = 0; i < 6 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== 16'(i + 1)) begin
                n_err++; $display("FAIL bp_order[%0d]: got %h want %h", i, obs[i], 16'(i + 1));
            end
        end
    endtask

    task automatic test_bubble();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = 16'($urandom); b = 16'($urandom);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = a; settle(); tick();
        bus.in_valid = 1'b0; settle(); tick(); settle(); tick();
        bus.in_valid = 1'b1; bus.in_data = b; settle(); tick();
        bus.in_valid = 1'b0;
        repeat (3) begin settle(); tick(); end
        bus.out_ready = 1'b1;
        settle();
        n_cmp++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, a}) begin
            n_err++; $display("FAIL bubble_first: got %h want %h", {bus.out_valid, bus.out_data}, {1'b1, a});
        end
        tick();
        settle();
        n_cmp++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, b}) begin
            n_err++; $display("FAIL bubble_second: got %h want %h", {bus.out_valid, bus.out_data}, {1'b1, b});
        end
        tick();
    endtask

    task automatic test_flush();
        logic [W-1:0] x;
        int t_out = -1;
        bus.out_ready = 1'b0; obs = {};
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'(16'h0100 + i);
            settle(); tick();
        end
        flush = 1'b1; bus.in_data = 16'hBEEF;
        settle();
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready);
        end
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        settle();
        n_cmp++;
        if ({bus.out_valid, bus.out_data} !== {1'b0, RV}) begin
            n_err++; $display("FAIL flush_outputs: got %h want %h", {bus.out_valid, bus.out_data}, {1'b0, RV});
        end
        x = 16'($urandom_range(0, 16'hBEEE));
        bus.in_valid = 1'b1; bus.in_data = x; bus.out_ready = 1'b1;
        settle(); tick();
        bus.in_valid = 1'b0;
        for (int cyc = 1; cyc < 10; cyc++) begin
            settle();
            if (bus.out_valid && t_out < 0) begin
                t_out = cyc;
                n_cmp++;
                if (bus.out_data !== x) begin
                    n_err++; $display("FAIL flush_next_data: got %h want %h", bus.out_data, x);
                end
            end
            tick();
        end
        n_cmp++;
        if (t_out !== D) begin
            n_err++; $display("FAIL flush_next_latency: got %0d want %0d", t_out, D);
        end
        n_cmp++;
        if (obs.size() !== 1 || obs[0] === 16'hBEEF) begin
            n_err++; $display("FAIL flush_discard: got %0d items want 1 (not BEEF)", obs.size());
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 39) == 0);
            r             = ($urandom_range(0, 149) == 0);
            settle();
            n_cmp++;
            if ({bus.in_ready, bus.out_valid, bus.out_data} !== e_vec) begin
                n_err++;
                $display("FAIL rand_cyc%0d: got %h want %h", cyc, {bus.in_ready, bus.out_valid, bus.out_data}, e_vec);
            end
`ifdef REG_PIPE_COUNT_EN
            n_cmp++;
            if (int'(count) !== m_dat.size()) begin
                n_err++; $display("FAIL rand_count cyc%0d: got %0d want %0d", cyc, count, m_dat.size());
            end
`endif
            tick();
        end
        r = 1'b0; flush = 1'b0; bus.in_valid = 1'b0;
    endtask

`ifdef REG_PIPE_COUNT_EN
    task automatic test_count();
        r = 1'b1; settle(); tick(); r = 1'b0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        repeat (3) begin bus.in_data = 16'($urandom); settle(); tick(); end
        bus.in_valid = 1'b0;
        settle();
        n_cmp++;
        if (count !== 3'd3) begin n_err++; $display("FAIL count_three: got %0d want 3", count); end
        tick();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        settle(); tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        settle();
        n_cmp++;
        if (count !== 3'd3) begin n_err++; $display("FAIL count_push_pop: got %0d want 3", count); end
        flush = 1'b1; settle(); tick(); flush = 1'b0;
        settle();
        n_cmp++;
        if (count !== 3'd0) begin n_err++; $display("FAIL count_flush: got %0d want 0", count); end
        bus.in_valid = 1'b1;
        repeat (6) begin bus.in_data = 16'($urandom); settle(); tick(); end
        bus.in_valid = 1'b0;
        settle();
        n_cmp++;
        if (count !== 3'd4) begin n_err++; $display("FAIL count_full: got %0d want 4", count); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_random();
`ifdef REG_PIPE_COUNT_EN
        test_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_pipe.md
Name: reg_pipe

Overview:
- Parametrised successor to the single-bit reset flip-flop: a DEPTH-stage, WIDTH-bit elastic register pipeline with valid/ready handshake, bubble collapsing, synchronous flush and a programmable reset value.
- Used as the standard retiming/delay element between datapath blocks that need backpressure.

Parameters:
- WIDTH, 16, data bits per stage (>=1).
- DEPTH, 4, number of register stages (>=1).
- RESET_VAL, 0 (WIDTH bits), value loaded into every data stage on reset and on flush.

Ports:
- clock  input  1  rising-edge clock.
- r  input  1  synchronous active-high reset.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  producer has data.
- in_data  input  WIDTH  producer data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- out_valid  output  1  stage DEPTH-1 holds data.
- out_data  output  WIDTH  stage DEPTH-1 data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Interface: one clock `clock`; reset `r` is synchronous and active-high, sampled only on the rising edge of `clock`.
- State: per stage i (0..DEPTH-1), valid v[i] and data d[i].
- Reset (r=1 at posedge): all v[i]=0 and all d[i]=RESET_VAL. Resulting outputs: out_valid=0, out_data=RESET_VAL, in_ready=1.
- Advance chain, combinational:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - For i<DEPTH-1: adv[i] = v[i] & (!v[i+1] | adv[i+1]).
  - in_ready = (!v[0] | adv[0]) & !flush & !r.
- Stage update at posedge:
  - Stage i>0 loads d[i-1], v[i-1] when (!v[i] | adv[i]).
  - Stage 0 loads in_data with valid (in_valid & in_ready) under the same condition.
  - A stage not loading holds its contents.
- Bubbles collapse. An item advances into any empty downstream stage even while the output is stalled.
- Latency: an item accepted at edge k presents out_valid=1 after edge k+DEPTH-1, i.e. DEPTH cycles from the in_valid/in_ready handshake to out_valid. This assumes no stalls.
- Throughput: 1 item/cycle sustained while out_ready=1.
- Full: all v=1 and out_ready=0 gives in_ready=0. out_ready rising gives in_ready=1 in the same cycle (combinational path).
- Empty: out_valid=0; out_data holds the last value (RESET_VAL after reset or flush).
- Ordering: strict FIFO; no item is dropped or duplicated.
- Data is transferred only on a valid/ready handshake. out_data is stable while out_valid=1 and out_ready=0.
- Flush (flush=1 at posedge):
  - All v[i]=0 and all d[i]=RESET_VAL.
  - in_ready=0 during the flush cycle, so in_data is not accepted.
  - The out_valid/out_ready handshake in that cycle still counts as consumed.
- Precedence: r > flush > normal operation.
- Reset or flush mid-stream discards all in-flight items. Operation resumes on the next cycle.
- DEPTH=1: degenerates to a single full-throughput register slice with the same rules.

Optional Feature:
- Macro: REG_PIPE_COUNT_EN.
- Defined:
  - Adds output port `count`, width $clog2(DEPTH+1), equal to the number of set v[i], registered.
  - Reset and flush set count to 0.
  - Simultaneous accept and emit leaves count unchanged.
  - count never exceeds DEPTH.
- Undefined: no `count` port and no counting logic.

Decomposition:
- Package reg_pipe_pkg:
  - Default constants REG_PIPE_WIDTH_DEF=16 and REG_PIPE_DEPTH_DEF=4.
  - A count-width function returning $clog2(DEPTH+1).
- Sub-module reg_pipe_stage:
  - Contents: one valid+data register with load/hold, reset/flush to RESET_VAL, and adv output logic.
  - Use: instantiated DEPTH times with a generate loop.

Test Plan:
- Reset: hold r=1 for 2 cycles with in_valid=1, in_data=16'hFFFF -> out_valid=0, out_data=RESET_VAL (16'h0000), in_ready=1; no item emerges afterwards.
- Streaming: DEPTH=4, out_ready=1, push 16'h0001..16'h0008 back-to-back -> out_valid rises 4 cycles after the first handshake; 0001..0008 emerge in order on consecutive cycles; in_ready stays 1 throughout.
- Backpressure: out_ready=0 and push 6 items -> in_ready falls after the 4th accept; out_data=0001 stays stable. Then raise out_ready -> in_ready=1 the same cycle; 0001..0006 emerge in order with no loss.
- Bubble collapse: push A, idle 2 cycles, push B with out_ready=0 -> A and B occupy stages 3 and 2. Raise out_ready -> A then B on consecutive cycles.
- Flush: pipeline holds 3 items and flush=1 coincides with in_valid=1 (data 16'hBEEF) -> next cycle out_valid=0, out_data=RESET_VAL; BEEF is never emitted; the next pushed item emerges after 4 cycles.
- REG_PIPE_COUNT_EN defined:
  - Push 3 with out_ready=0 -> count=3.
  - One simultaneous push+pop -> count=3.
  - Flush -> count=0.
  - Fill to 4 -> count=4, never 5.
